// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the instruction/data memory-bus arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} arb_state_t;
   typedef enum logic {GR_INSTR, GR_DATA} grant_t;

   // Counter width for a given timeout; never below one bit, so TIMEOUT=0 still elaborates.
   function automatic int arb_cnt_w(input int t);
      return (t < 1) ? 1 : $clog2(t + 1);
   endfunction

   localparam int ARB_TIMEOUT_DEF = 16;
   localparam int ARB_CNT_W       = arb_cnt_w(ARB_TIMEOUT_DEF);

endpackage

// File: rtl/arb_timeout_cnt.sv
// Bus wait-cycle counter; flags the bus cycle that reaches LIMIT without an ack.
module arb_timeout_cnt
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = ARB_TIMEOUT_DEF,
   parameter int CW    = arb_cnt_w(LIMIT)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [CW-1:0] LIM_M1 = CW'((LIMIT == 0) ? 0 : LIMIT - 1);

   logic [CW-1:0] cnt;

   // Combinational so the abort happens on the edge that closes the LIMIT-th bus cycle.
   assign expired = (LIMIT != 0) && en && (cnt == LIM_M1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && !expired)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Merges the fetch port and the load/store port onto one shared memory bus with handshake and timeout.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int PRIORITY = 0,
   parameter int TIMEOUT  = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_ready,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_read,
   input  logic            d_write,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_sel,
   output logic            d_ready,
   output logic [DW-1:0]   d_rdata,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_sel,
   output logic            m_rd,
   output logic            m_wr,
   input  logic [DW-1:0]   m_rdata,
   input  logic            m_ack,
   output logic            bus_err
);

   arb_state_t state;
   grant_t     last_grant;
   grant_t     gnt;
   logic       d_req;
   logic       gnt_vld;
   logic       on_bus;
   logic       tmo_expired;

   assign d_req   = d_read | d_write;
   assign gnt_vld = i_req | d_req;
   assign on_bus  = (state == BUS_I) || (state == BUS_D);

   always_comb begin
      gnt = GR_INSTR;
      if (i_req && d_req)
         gnt = (PRIORITY == 0) ? GR_DATA :
               ((last_grant == GR_INSTR) ? GR_DATA : GR_INSTR);
      else if (d_req)
         gnt = GR_DATA;
   end

   arb_timeout_cnt #(
      .LIMIT (TIMEOUT),
      .CW    (arb_cnt_w(TIMEOUT))
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == IDLE),
      .en      (on_bus),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GR_INSTR;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_sel      <= '0;
         m_rd       <= 1'b0;
         m_wr       <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         i_ready    <= 1'b0;
         d_ready    <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_vld) begin
                  last_grant <= gnt;
                  if (gnt == GR_DATA) begin
                     // A simultaneous read+write request is carried out as a write.
                     m_addr  <= d_addr;
                     m_wdata <= d_wdata;
                     m_sel   <= d_write ? d_sel : '1;
                     m_rd    <= ~d_write;
                     m_wr    <= d_write;
                     state   <= BUS_D;
                  end else begin
                     m_addr  <= i_addr;
                     m_wdata <= '0;
                     m_sel   <= '1;
                     m_rd    <= 1'b1;
                     m_wr    <= 1'b0;
                     state   <= BUS_I;
                  end
               end
            end
            BUS_I, BUS_D: begin
               if (m_ack) begin
                  m_rd  <= 1'b0;
                  m_wr  <= 1'b0;
                  state <= RESP;
                  if (state == BUS_I) begin
                     i_rdata <= m_rdata;
                     i_ready <= 1'b1;
                  end else begin
                     d_ready <= 1'b1;
                     if (m_rd)
                        d_rdata <= m_rdata;
                  end
               end else if (tmo_expired) begin
                  m_rd    <= 1'b0;
                  m_wr    <= 1'b0;
                  bus_err <= 1'b1;
                  state   <= RESP;
                  if (state == BUS_I) begin
                     i_rdata <= '0;
                     i_ready <= 1'b1;
                  end else begin
                     d_rdata <= '0;
                     d_ready <= 1'b1;
                  end
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: instance A (fixed data priority, timeout 4), instance B (round-robin, timeout 16).
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_read, d_write, m_ack;
   logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
   logic [3:0]  d_sel;

   logic        a_i_ready, a_d_ready, a_m_rd, a_m_wr, a_bus_err;
   logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata;
   logic [3:0]  a_m_sel;
   logic        b_i_ready, b_d_ready, b_m_rd, b_m_wr, b_bus_err;
   logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata;
   logic [3:0]  b_m_sel;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.AW(32), .DW(32), .PRIORITY(0), .TIMEOUT(4)) u_a (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ready(a_i_ready), .i_rdata(a_i_rdata),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
      .d_ready(a_d_ready), .d_rdata(a_d_rdata),
      .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_sel(a_m_sel), .m_rd(a_m_rd), .m_wr(a_m_wr),
      .m_rdata(m_rdata), .m_ack(m_ack), .bus_err(a_bus_err)
   );

   mem_bus_arbiter #(.AW(32), .DW(32), .PRIORITY(1), .TIMEOUT(16)) u_b (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ready(b_i_ready), .i_rdata(b_i_rdata),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
      .d_ready(b_d_ready), .d_rdata(b_d_rdata),
      .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_sel(b_m_sel), .m_rd(b_m_rd), .m_wr(b_m_wr),
      .m_rdata(m_rdata), .m_ack(m_ack), .bus_err(b_bus_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      i_req = 0; d_read = 0; d_write = 0; m_ack = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; d_sel = '0; m_rdata = '0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   initial begin
      reset_dut();
      chk("rst_i_ready", a_i_ready, 0);
      chk("rst_d_ready", a_d_ready, 0);
      chk("rst_strobes", {a_m_rd, a_m_wr, a_bus_err}, 0);
      chk("rst_m_bus",   {a_m_addr, a_m_wdata}, 0);
      chk("rst_m_sel",   a_m_sel, 0);
      chk("rst_rdata",   {a_i_rdata, a_d_rdata}, 0);

      // 1: fetch with two wait states
      i_req = 1; i_addr = 32'h4;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("t1_m_rd", a_m_rd, 1);
         chk("t1_m_addr", a_m_addr, 32'h4);
         chk("t1_m_sel", a_m_sel, 4'hF);
      end
      m_ack = 1; m_rdata = 32'h3E80_0093;
      tick();
      m_ack = 0; i_req = 0;
      chk("t1_i_ready", a_i_ready, 1);
      chk("t1_i_rdata", a_i_rdata, 32'h3E80_0093);
      chk("t1_m_rd_drop", a_m_rd, 0);
      chk("t1_d_ready", a_d_ready, 0);
      tick();
      chk("t1_i_ready_pulse", a_i_ready, 0);

      // 2: tie with fixed priority, data first then fetch
      i_req = 1; i_addr = 32'h40; d_read = 1; d_addr = 32'h100;
      tick();
      chk("t2_d_first", a_m_addr, 32'h100);
      chk("t2_m_rd", a_m_rd, 1);
      m_ack = 1; m_rdata = 32'h1111_1111;
      tick();
      m_ack = 0; d_read = 0;
      chk("t2_d_ready", a_d_ready, 1);
      chk("t2_i_ready_lo", a_i_ready, 0);
      chk("t2_d_rdata", a_d_rdata, 32'h1111_1111);
      tick();
      chk("t2_gap", a_m_rd, 0);
      tick();
      chk("t2_i_addr", a_m_addr, 32'h40);
      chk("t2_i_rd", a_m_rd, 1);
      m_ack = 1; m_rdata = 32'h2222_2222;
      tick();
      m_ack = 0; i_req = 0;
      chk("t2_i_ready", a_i_ready, 1);
      chk("t2_d_ready_lo", a_d_ready, 0);
      chk("t2_i_rdata", a_i_rdata, 32'h2222_2222);
      tick();

      // 4: store leaves d_rdata untouched
      d_write = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_sel = 4'b0011;
      tick();
      chk("t4_m_wr", a_m_wr, 1);
      chk("t4_m_rd", a_m_rd, 0);
      chk("t4_m_sel", a_m_sel, 4'b0011);
      chk("t4_m_wdata", a_m_wdata, 32'hDEAD_BEEF);
      chk("t4_m_addr", a_m_addr, 32'h200);
      m_ack = 1; m_rdata = 32'h9999_9999;
      tick();
      m_ack = 0; d_write = 0;
      chk("t4_d_ready", a_d_ready, 1);
      chk("t4_d_rdata_keep", a_d_rdata, 32'h1111_1111);
      chk("t4_m_wr_drop", a_m_wr, 0);
      tick();

      // 5: load times out after four bus cycles
      d_read = 1; d_addr = 32'h300;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("t5_m_rd", a_m_rd, 1);
         chk("t5_no_err", a_bus_err, 0);
      end
      tick();
      d_read = 0;
      chk("t5_m_rd_drop", a_m_rd, 0);
      chk("t5_bus_err", a_bus_err, 1);
      chk("t5_d_ready", a_d_ready, 1);
      chk("t5_d_rdata0", a_d_rdata, 0);
      tick();
      chk("t5_err_pulse", a_bus_err, 0);
      chk("t5_rdy_pulse", a_d_ready, 0);

      // 5b: ack on the limit cycle beats the timeout
      d_read = 1; d_addr = 32'h304;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (c == 3) begin
            m_ack = 1; m_rdata = 32'h77;
         end
      end
      tick();
      m_ack = 0; d_read = 0;
      chk("t5b_no_err", a_bus_err, 0);
      chk("t5b_d_ready", a_d_ready, 1);
      chk("t5b_d_rdata", a_d_rdata, 32'h77);
      tick();

      // 3: round-robin on instance B; a lone load first makes last grant DATA
      reset_dut();
      d_read = 1; d_addr = 32'h180; i_addr = 32'h80;
      tick();
      chk("t3_pre_addr", b_m_addr, 32'h180);
      m_ack = 1;
      tick();
      m_ack = 0;
      chk("t3_pre_ready", b_d_ready, 1);
      i_req = 1;
      tick();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t3_grant", b_m_addr, (k % 2 == 0) ? 32'h80 : 32'h180);
         chk("t3_m_rd", b_m_rd, 1);
         m_ack = 1; m_rdata = k;
         tick();
         m_ack = 0;
         chk("t3_i_ready", b_i_ready, (k % 2 == 0) ? 1 : 0);
         chk("t3_d_ready", b_d_ready, (k % 2 == 0) ? 0 : 1);
         chk("t3_excl", b_i_ready & b_d_ready, 0);
         tick();
      end
      i_req = 0; d_read = 0;
      tick();

      // 6: async reset in the middle of a fetch
      reset_dut();
      i_req = 1; i_addr = 32'h8;
      tick();
      chk("t6_busy", a_m_rd, 1);
      rst = 1;
      #1;
      chk("t6_rst_rd", a_m_rd, 0);
      chk("t6_rst_addr", a_m_addr, 0);
      chk("t6_rst_sel", a_m_sel, 0);
      tick();
      rst = 0;
      tick();
      chk("t6_regrant", a_m_rd, 1);
      chk("t6_addr", a_m_addr, 32'h8);
      m_ack = 1; m_rdata = 32'h5;
      tick();
      m_ack = 0; i_req = 0;
      chk("t6_i_ready", a_i_ready, 1);
      chk("t6_i_rdata", a_i_rdata, 32'h5);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
